// File: rtl/crc_packet_tx_seq.sv
// Framed byte transmitter: SYNC, 4 payload bytes MSB first, CRC-8 (poly 0xD5, init 0x00),
// followed by a programmable idle gap before the next word is accepted.
module crc_packet_tx_seq #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PAY,
        S_CRC,
        S_GAP
    } state_t;

    // With a zero-length gap a finished or aborted frame returns straight to IDLE.
    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t           state_q, state_d;
    logic [31:0]      shift_q, shift_d;
    logic [7:0]       crc_q, crc_d;
    logic [1:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c_in);
        logic [7:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'hD5) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            crc_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            crc_q   <= crc_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        pkt_d     = pkt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = '0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = in_data;
                    crc_d   = '0;
                    idx_d   = '0;
                    state_d = S_SYNC;
                end
            end

            S_SYNC: begin
                out_valid = 1'b1;
                out_byte  = SYNC_BYTE;
                if (abort) begin
                    gap_d   = GAP_LOAD;
                    state_d = AFTER_FRAME;
                end else if (out_ready) begin
                    idx_d   = '0;
                    state_d = S_PAY;
                end
            end

            S_PAY: begin
                out_valid = 1'b1;
                out_byte  = shift_q[31:24];
                if (abort) begin
                    gap_d   = GAP_LOAD;
                    state_d = AFTER_FRAME;
                end else if (out_ready) begin
                    crc_d   = crc8_step(crc_q ^ shift_q[31:24]);
                    shift_d = {shift_q[23:0], 8'h00};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_CRC;
                    end
                end
            end

            S_CRC: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_byte  = crc_q;
                if (abort) begin
                    gap_d   = GAP_LOAD;
                    state_d = AFTER_FRAME;
                end else if (out_ready) begin
                    pkt_d   = pkt_q + CNT_W'(1);
                    gap_d   = GAP_LOAD;
                    state_d = AFTER_FRAME;
                end
            end

            S_GAP: begin
                // Loaded with GAP_CYCLES on entry, so the state lasts exactly that many cycles.
                if (gap_q > GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_crc_packet_tx_seq.sv
// Bench for crc_packet_tx_seq: one instance with the default 4-cycle gap, one with
// a zero gap and a 2-bit counter for back-to-back framing and counter wrap.
module tb_crc_packet_tx_seq;

    localparam int TB_GAP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default gap, 16-bit counter
    logic        rst0, in_valid0, in_ready0, out_valid0, out_ready0, out_last0, abort0, busy0;
    logic [31:0] in_data0;
    logic [7:0]  out_byte0;
    logic [15:0] pkt0;

    // Instance 1: zero gap, 2-bit counter
    logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, abort1, busy1;
    logic [31:0] in_data1;
    logic [7:0]  out_byte1;
    logic [1:0]  pkt1;

    crc_packet_tx_seq #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(TB_GAP), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_byte(out_byte0), .out_valid(out_valid0), .out_ready(out_ready0), .out_last(out_last0),
        .abort(abort0), .busy(busy0), .pkt_count(pkt0)
    );

    crc_packet_tx_seq #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_byte(out_byte1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
        .abort(abort1), .busy(busy1), .pkt_count(pkt1)
    );

    int total = 0;
    int bad   = 0;
    int exp_pkt0 = 0;
    logic [15:0] lfsr = 16'hACE1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of payload * x^8 divided by x^8+x^7+x^6+x^4+x^2+1.
    function automatic logic [7:0] ref_crc(input logic [31:0] d);
        logic [39:0] v;
        v = {d, 8'h00};
        for (int b = 39; b >= 8; b--) begin
            if (v[b]) v = v ^ (40'h1D5 << (b - 8));
        end
        return v[7:0];
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] d, input int i);
        logic [7:0] r;
        case (i)
            0:       r = 8'hA5;
            1:       r = d[31:24];
            2:       r = d[23:16];
            3:       r = d[15:8];
            4:       r = d[7:0];
            default: r = ref_crc(d);
        endcase
        return r;
    endfunction

    task automatic step_lfsr();
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    endtask

    // Sends one word on instance 0. abort_at = frame byte index (0=SYNC..5=CRC) at which abort
    // accompanies the handshake; anything >5 means no abort.
    task automatic send0(input logic [31:0] d, input bit bp, input int abort_at,
                         output logic [7:0] crc_seen);
        int n, cyc, gap;
        bit aborted;
        crc_seen = '0;
        cyc = 0;
        while (!in_ready0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("idle_in_ready", in_ready0, 1);
        in_data0  = d;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_data0  = $urandom;
        n = 0;
        cyc = 0;
        aborted = 1'b0;
        while (n < 6 && cyc < 300) begin
            check("frame_byte", out_byte0, ref_byte(d, n));
            check("frame_valid", out_valid0, 1);
            check("frame_last", out_last0, (n == 5));
            if (n == 5) crc_seen = out_byte0;
            out_ready0 = bp ? lfsr[0] : 1'b1;
            step_lfsr();
            abort0 = (n == abort_at) && out_ready0;
            @(posedge clk); #1;
            if (abort0) begin
                abort0  = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (out_ready0) n++;
            cyc++;
        end
        out_ready0 = 1'b1;
        if (!aborted && n < 6) check("frame_timeout", n, 6);
        if (!aborted) exp_pkt0++;
        check("pkt_count", pkt0, exp_pkt0[15:0]);
        gap = 0;
        while (!in_ready0 && gap < 50) begin
            check("gap_quiet", {out_valid0, out_last0}, 2'b00);
            @(posedge clk); #1;
            gap++;
        end
        check("gap_len", gap, TB_GAP);
    endtask

    task automatic frame1(input logic [31:0] d, input logic [1:0] exp_cnt);
        in_data1  = d;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("g0_byte", out_byte1, ref_byte(d, i));
            check("g0_last", out_last1, (i == 5));
            @(posedge clk); #1;
        end
        check("wrap_count", pkt1, exp_cnt);
        check("g0_ready", in_ready1, 1);
    endtask

    typedef struct {
        logic [31:0] data;
        bit          bp;
        logic [7:0]  crc;
    } vec_t;

    initial begin
        vec_t tbl[5];
        logic [7:0] seen;
        logic [31:0] w;

        tbl[0] = '{32'h000000FF, 1'b0, 8'hF9};
        tbl[1] = '{32'h00000100, 1'b0, 8'h0B};
        tbl[2] = '{32'h00000001, 1'b0, 8'hD5};
        tbl[3] = '{32'h00000000, 1'b0, 8'h00};
        tbl[4] = '{32'h000000FF, 1'b1, 8'hF9};

        rst0 = 1'b1; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1; abort0 = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1; abort1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_last", out_last0, 0);
        check("rst_out_byte", out_byte0, 8'h00);
        check("rst_busy", busy0, 0);
        check("rst_pkt", pkt0, 0);
        check("rst_pkt_g0", pkt1, 0);

        // Known CRC vectors, last one under LFSR backpressure
        for (int i = 0; i < 5; i++) begin
            send0(tbl[i].data, tbl[i].bp, 99, seen);
            check("tbl_crc", seen, tbl[i].crc);
        end

        // Abort alongside the handshake on the second payload byte
        send0(32'hDEADBEEF, 1'b0, 2, seen);

        // Abort while idle is ignored
        abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        check("idle_abort_busy", busy0, 0);
        check("idle_abort_ready", in_ready0, 1);
        check("idle_abort_pkt", pkt0, exp_pkt0[15:0]);

        // Random words, random backpressure, occasional abort
        for (int i = 0; i < 24; i++) begin
            send0($urandom, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), seen);
        end

        // Reset in the middle of the payload
        in_data0  = 32'h12345678;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", busy0, 1);
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        exp_pkt0 = 0;
        check("midrst_valid", out_valid0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_pkt", pkt0, 0);
        @(posedge clk); #1;
        check("midrst_quiet", out_valid0, 0);

        // Zero gap: back-to-back with in_valid held high
        w = 32'hCAFEF00D;
        in_data1   = w;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        in_data1 = 32'h00000100;
        for (int i = 0; i < 6; i++) begin
            check("b2b_byte1", out_byte1, ref_byte(w, i));
            @(posedge clk); #1;
        end
        check("b2b_idle_ready", in_ready1, 1);
        check("b2b_idle_valid", out_valid1, 0);
        check("b2b_pkt1", pkt1, 2'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("b2b_byte2", out_byte1, ref_byte(32'h00000100, i));
            @(posedge clk); #1;
        end
        check("b2b_pkt2", pkt1, 2'd2);

        // Counter wrap on the 2-bit instance
        frame1(32'h01020304, 2'd3);
        frame1(32'hFFFFFFFF, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_packet_tx_seq.md
Name: crc_packet_tx_seq

Overview:
- Transmit-side sequencer for the application-layer link. Accepts one 32-bit payload word via valid/ready and emits a framed byte stream: SYNC byte, 4 payload bytes (MSB first), then a CRC-8 byte.
- Controls an internal 32-to-8 shift-out register and a byte-serial CRC-8 engine (DVB-S2 polynomial 0xD5, init 0x00).
- Enforces a programmable inter-packet idle gap.
- Sits between the packet source and the byte-wide PHY serializer.

Parameters:
- SYNC_BYTE, 8'hA5, value of the first byte of every frame.
- GAP_CYCLES, 4, idle cycles inserted after each frame ends (completed or aborted); 0 is legal.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  payload word.
- in_valid  in  1  payload word is valid.
- in_ready  out  1  block can accept a word.
- out_byte  out  8  current frame byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  downstream accepts out_byte.
- out_last  out  1  asserted with the CRC byte.
- abort  in  1  cancel the frame in progress.
- busy  out  1  state is not IDLE.
- pkt_count  out  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset:
  - One clock and reset are fixed. rst is sampled only on the rising edge of clk.
  - Reset forces state=IDLE, crc=8'h00, shift register=0, gap counter=0, pkt_count=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_byte=8'h00, busy=0.
  - Reset mid-frame discards the frame; no further bytes are emitted.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_ready=1 only in IDLE.
  - While out_valid=1 and out_ready=0: out_byte, out_valid and out_last hold stable.
- States:
  - IDLE: on input transfer, load in_data into the shift register, clear crc to 0x00, go to SYNC.
  - SYNC: out_byte=SYNC_BYTE. On output transfer, go to PAY with byte index 0.
  - PAY: out_byte = shift register [31:24].
    - On output transfer: crc <= CRC8_step(crc ^ out_byte), shift the register left 8, increment the index.
    - After index 3 transfers, go to CRC.
  - CRC: out_byte=crc, out_last=1. On output transfer: increment pkt_count (wrap), load the gap counter with GAP_CYCLES, go to GAP. If GAP_CYCLES=0, go straight to IDLE.
  - GAP: out_valid=0, in_ready=0. The counter decrements each cycle; on reaching 0, go to IDLE. The gap holds GAP_CYCLES full cycles.
- CRC rules:
  - The SYNC byte is excluded from the CRC.
  - CRC8_step is the standard MSB-first byte update for polynomial 0xD5 (table or 8 unrolled bit steps, combinational).
  - The result equals the CRC-8 of the 32-bit payload taken MSB-byte first.
- Latency:
  - Word accepted at cycle N: SYNC byte valid at N+1.
  - With out_ready held at 1, the frame occupies cycles N+1..N+6 and in_ready returns at N+7+GAP_CYCLES.
- Abort:
  - Abort in SYNC, PAY or CRC: go to GAP with the gap counter loaded to GAP_CYCLES. pkt_count is unchanged and out_last is never emitted.
  - Abort wins over a simultaneous output handshake; that byte counts as not transferred.
  - Abort in IDLE or GAP is ignored.
- Priority: rst > abort > handshake.
- in_valid outside IDLE is ignored; no buffering.
- pkt_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Basic frame: rst, then in_data=32'h000000FF with out_ready=1 -> bytes A5,00,00,00,FF,F9; out_last only on F9; pkt_count=1; in_ready high again 4 cycles after the F9 transfer.
- CRC check: in_data=32'h00000100 -> CRC byte 0x0B. in_data=32'h00000001 -> CRC 0xD5. in_data=0 -> CRC 0x00.
- Backpressure: toggle out_ready 1,0,0,1,… pseudo-randomly (LFSR-driven) during a frame -> out_byte/out_valid/out_last stable whenever stalled; byte sequence identical to the basic-frame case.
- Abort: assert abort together with the handshake on the 2nd payload byte -> that byte not counted, no further bytes, no out_last, pkt_count unchanged, in_ready after GAP_CYCLES. Abort in IDLE -> no effect.
- Gap = 0 and back-to-back: GAP_CYCLES=0, in_valid held high with two words -> second SYNC appears the cycle after IDLE re-entry; pkt_count=2.
- Reset and wrap: assert rst mid-PAY -> next cycle out_valid=0, busy=0, pkt_count=0. With CNT_W=2, send 4 frames -> pkt_count 1,2,3,0.
